// File: rtl/pmem_arb_pkg.sv
// Shared types and defaults for the pmem arbiter between the icache and the dcache.
// Also holds the round-robin winner selection used in the idle state.
package pmem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LINE_WIDTH_DEF = 256;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ICACHE = 2'd1,
    ARB_DCACHE = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } requester_t;

  // Only meaningful when at least one request is present; a tie goes to
  // whichever requester was not served last.
  function automatic requester_t pick_winner(input logic       i_req,
                                             input logic       d_req,
                                             input requester_t last_grant);
    requester_t winner;
    if (i_req && d_req) begin
      winner = (last_grant == REQ_DCACHE) ? REQ_ICACHE : REQ_DCACHE;
    end else if (i_req) begin
      winner = REQ_ICACHE;
    end else begin
      winner = REQ_DCACHE;
    end
    return winner;
  endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory line port between the icache and the dcache.
// One grant at a time; the granted request is latched and replayed downstream until mem_resp.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // icache side
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  // dcache side
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  // downstream line port
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  // debug view of the arbiter state
  output arb_state_t            arb_state_o
);

  // Handshake: requests are levels held until the matching *_resp pulse;
  // mem_read/mem_write are levels held until mem_resp, which is a one-cycle
  // pulse that completes the transfer in the cycle it is seen.

  arb_state_t            state_q, state_d;
  requester_t            last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;  // 1 = write-back, 0 = line read

  logic                  i_req;
  logic                  d_req;
  requester_t            winner;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  assign winner = pick_winner(i_req, d_req, last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          if (winner == REQ_ICACHE) begin
            state_d = ARB_ICACHE;
            addr_d  = i_pmem_address;
            rw_d    = 1'b0;
          end else begin
            // A simultaneous read and write from the dcache resolves to the write-back.
            state_d = ARB_DCACHE;
            addr_d  = d_pmem_address;
            wdata_d = d_pmem_wdata;
            rw_d    = d_pmem_write;
          end
        end
      end
      ARB_ICACHE: begin
        if (mem_resp) begin
          state_d      = ARB_IDLE;
          last_grant_d = REQ_ICACHE;
        end
      end
      ARB_DCACHE: begin
        if (mem_resp) begin
          state_d      = ARB_IDLE;
          last_grant_d = REQ_DCACHE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Downstream drive comes only from the latched request, never from live inputs.
  always_comb begin
    mem_read     = (state_q != ARB_IDLE) && !rw_q;
    mem_write    = (state_q != ARB_IDLE) && rw_q;
    mem_address  = addr_q;
    mem_wdata    = wdata_q;
    i_pmem_resp  = (state_q == ARB_ICACHE) && mem_resp;
    d_pmem_resp  = (state_q == ARB_DCACHE) && mem_resp;
    i_pmem_rdata = mem_rdata;
    d_pmem_rdata = mem_rdata;
    arb_state_o  = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= REQ_DCACHE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
    end
  end

  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read && mem_write));

  a_resp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pmem_resp && d_pmem_resp));

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-requester arbiter that shares the single physical-memory line port between the instruction cache and the data cache. It sits between the two cache controllers' pmem interfaces and the cacheline adaptor. It grants one requester at a time, latches its request, holds the downstream request until the line transfer completes, and returns the response pulse only to the granted cache. Tie-breaks are round-robin.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 256, cache line width in bits

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- i_pmem_read  in  1  icache line-read request, level, held until i_pmem_resp
- i_pmem_address  in  ADDR_WIDTH  icache line address
- i_pmem_rdata  out  LINE_WIDTH  line data to icache; valid only while i_pmem_resp=1
- i_pmem_resp  out  1  one-cycle completion pulse to icache
- d_pmem_read  in  1  dcache line-read request, level
- d_pmem_write  in  1  dcache line write-back request, level
- d_pmem_address  in  ADDR_WIDTH  dcache line address
- d_pmem_wdata  in  LINE_WIDTH  dcache write-back line
- d_pmem_rdata  out  LINE_WIDTH  line data to dcache; valid only while d_pmem_resp=1
- d_pmem_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  downstream read request
- mem_write  out  1  downstream write request
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  LINE_WIDTH  downstream write line
- mem_rdata  in  LINE_WIDTH  downstream read line, valid with mem_resp
- mem_resp  in  1  downstream completion pulse

## Operation
- States: ARB_IDLE, ARB_ICACHE, ARB_DCACHE.
- Request vector: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
- ARB_IDLE:
  - mem_read = mem_write = 0.
  - On a clock edge with only i_req: latch i_pmem_address, set rw = read, go to ARB_ICACHE.
  - On a clock edge with only d_req: latch d address, wdata and rw, go to ARB_DCACHE. If d_pmem_read and d_pmem_write are both set, write wins.
  - With both requests: grant the requester that was not last_grant.
- ARB_ICACHE / ARB_DCACHE:
  - Drive mem_read or mem_write, mem_address and mem_wdata from the latched registers only, never from live inputs.
  - On the cycle mem_resp=1:
    - pulse the granted cache's *_resp combinationally in that same cycle;
    - update last_grant to the granted requester;
    - next state is ARB_IDLE.
- rdata: mem_rdata is routed combinationally to both i_pmem_rdata and d_pmem_rdata. Caches qualify it with their own resp.
- Requester deasserting mid-grant is a protocol violation. The transfer still completes from the latch, and the resp pulse is still issued.
- mem_resp in ARB_IDLE is ignored; no resp is issued.
- The non-granted requester's inputs are ignored until the arbiter returns to ARB_IDLE.

## Timing
- Reset (rst_n=0, asynchronous):
  - state = ARB_IDLE.
  - last_grant = DCACHE, so icache wins the first tie.
  - Latches cleared to 0.
  - mem_read, mem_write, i_pmem_resp, d_pmem_resp = 0; mem_address = 0; mem_wdata = 0.
- Reset asserted mid-transfer aborts the grant; no resp is issued. Downstream must also be reset.
- Arbitration latency: 1 cycle. A request seen in ARB_IDLE at edge N drives mem_* from edge N.
- Resp latency is the downstream latency plus 0 cycles. After resp, there is 1 mandatory ARB_IDLE cycle before the next grant.
- Back-to-back:
  - The dcache write-back followed by its refill read costs one idle cycle between them.
  - If the icache is waiting, it is granted in between, because last_grant = DCACHE.
- Fairness: with both requesting continuously, grants alternate I, D, I, D. Neither requester waits more than one foreign transfer.
- mem_read and mem_write are never both 1. They are constant for the whole grant.

## Structure
- Shared package (pmem_arb_pkg):
  - typedef enum arb_state_t {ARB_IDLE, ARB_ICACHE, ARB_DCACHE};
  - typedef enum requester_t {REQ_ICACHE, REQ_DCACHE};
  - ADDR_WIDTH/LINE_WIDTH defaults.
- Single module with two always_comb blocks (next-state, outputs) and one always_ff with async reset (state, last_grant, latches).
- No sub-module required.

## Test plan
- Icache-only read:
  - Stimulus: i_pmem_read=1, addr 0x0000_1040; mem_resp after 4 cycles with rdata 0xA5…A5.
  - Required: mem_read=1 and mem_address=0x0000_1040 from the next edge; i_pmem_resp=1 for exactly 1 cycle with i_pmem_rdata=0xA5…A5; d_pmem_resp stays 0.
- Dcache write-back then refill:
  - Stimulus: d_pmem_write=1, addr 0x0000_2000, wdata 0x1234…; after resp, d_pmem_read=1, addr 0x0000_3000.
  - Required: mem_write transfer carries the latched wdata; one ARB_IDLE cycle follows; then mem_read at 0x0000_3000.
- Simultaneous first requests after reset:
  - Stimulus: i and d both request.
  - Required: icache is granted first, dcache second; then both re-request and the order is I, D again.
- Input change mid-grant:
  - Stimulus: during ARB_DCACHE, change d_pmem_address to 0xFFFF_FFE0 and drop d_pmem_write.
  - Required: mem_address stays at the latched value; d_pmem_resp still pulses.
- Reset mid-transfer:
  - Stimulus: assert rst_n=0 during ARB_ICACHE.
  - Required: all outputs are 0 immediately, without waiting for a clock edge; after release the state is ARB_IDLE and a stray mem_resp produces no resp.
